// File: rtl/arith_seq.sv
// Sequencer for the shared multiplier/divider datapath: chunks whole operands into
// 32-bit writes, starts the op, waits with timeout, reads back and returns the result.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// LOAD  | writing operand chunks 0..7
// START | one-cycle start pulse
// WAIT  | polling done, timeout counter running
// READ  | issuing chunk reads, capturing one cycle behind
// RESP  | result presented until rsp_ready
// CLEAR | one-cycle datapath clear
module arith_seq #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_op,
   input  logic [127:0] cmd_a,
   input  logic [127:0] cmd_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_err,
   output logic [255:0] rsp_data,
   output logic [31:0]  dp_select,
   output logic [31:0]  dp_in_loc,
   output logic [31:0]  dp_in_val,
   output logic [31:0]  dp_ctrl,
   input  logic [31:0]  dp_out_val,
   input  logic [31:0]  dp_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_RESP, S_CLEAR
   } state_t;

   localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYC - 1);

   state_t        state;
   logic          op_r;
   logic          skip_clr;
   logic [127:0]  a_r;
   logic [127:0]  b_r;
   logic [2:0]    k;
   logic [3:0]    j;
   logic [31:0]   wcnt;
   logic [3:0]    n_rd;

   logic unused_state;
   assign unused_state = ^{dp_state[31:2], dp_state[0]};

   assign n_rd = op_r ? 4'd4 : 4'd8;

   // Divide only uses the low 64 bits of each operand; chunks 2,3,6,7 go out as zero.
   function automatic logic [31:0] chunk(input logic op, input logic [127:0] a,
                                         input logic [127:0] b, input logic [2:0] idx);
      if (op && idx[1])
         return '0;
      return idx[2] ? b[32*int'(idx[1:0]) +: 32] : a[32*int'(idx[1:0]) +: 32];
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         dp_select <= '0;
         dp_in_loc <= '0;
         dp_in_val <= '0;
         dp_ctrl   <= '0;
         op_r      <= 1'b0;
         skip_clr  <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         k         <= '0;
         j         <= '0;
         wcnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  op_r      <= cmd_op;
                  a_r       <= cmd_a;
                  b_r       <= cmd_b;
                  dp_select <= {31'b0, cmd_op};
                  rsp_data  <= '0;
                  rsp_err   <= 1'b0;
                  if (cmd_op && cmd_b[63:0] == 64'd0) begin
                     skip_clr  <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     skip_clr  <= 1'b0;
                     k         <= '0;
                     dp_in_loc <= '0;
                     dp_in_val <= chunk(cmd_op, cmd_a, cmd_b, 3'd0);
                     state     <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (k == 3'd7) begin
                  dp_ctrl   <= 32'd1;
                  dp_in_loc <= '0;
                  dp_in_val <= '0;
                  state     <= S_START;
               end else begin
                  k         <= k + 3'd1;
                  dp_in_loc <= {29'b0, k + 3'd1};
                  dp_in_val <= chunk(op_r, a_r, b_r, k + 3'd1);
               end
            end
            S_START: begin
               dp_ctrl <= '0;
               wcnt    <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (dp_state[1]) begin
                  dp_ctrl   <= 32'd3;
                  dp_in_loc <= '0;
                  j         <= '0;
                  state     <= S_READ;
               end else if (wcnt == WAIT_LAST) begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  wcnt <= wcnt + 32'd1;
               end
            end
            S_READ: begin
               // j counts issues; the chunk issued at j-1 is on dp_out_val now
               if (j != 4'd0)
                  rsp_data[32*(int'(j) - 1) +: 32] <= dp_out_val;
               if (j == n_rd) begin
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (j == n_rd - 4'd1) begin
                  dp_ctrl   <= '0;
                  dp_in_loc <= '0;
                  j         <= j + 4'd1;
               end else begin
                  j         <= j + 4'd1;
                  dp_in_loc <= {28'b0, j + 4'd1};
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (skip_clr) begin
                     cmd_ready <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     dp_ctrl <= 32'd2;
                     state   <= S_CLEAR;
                  end
               end
            end
            S_CLEAR: begin
               dp_ctrl   <= '0;
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arith_seq.sv
// Bench for arith_seq: directed commands against a behavioural datapath model,
// responses checked by a queue-based scoreboard monitor.
module tb_arith_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_op;
   logic [127:0] cmd_a;
   logic [127:0] cmd_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_err;
   logic [255:0] rsp_data;
   logic [31:0]  dp_select;
   logic [31:0]  dp_in_loc;
   logic [31:0]  dp_in_val;
   logic [31:0]  dp_ctrl;
   logic [31:0]  dp_out_val;
   logic [31:0]  dp_state;

   arith_seq #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_data(rsp_data),
      .dp_select(dp_select), .dp_in_loc(dp_in_loc), .dp_in_val(dp_in_val),
      .dp_ctrl(dp_ctrl), .dp_out_val(dp_out_val), .dp_state(dp_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // datapath model
   int           dlat = 5;
   logic         hang = 1'b0;
   logic [31:0]  regs [8];
   logic         busy;
   int           mcnt;
   logic [255:0] res;
   logic [127:0] ma, mb;
   logic [63:0]  da, db;

   assign ma = {regs[3], regs[2], regs[1], regs[0]};
   assign mb = {regs[7], regs[6], regs[5], regs[4]};
   assign da = {regs[1], regs[0]};
   assign db = {regs[5], regs[4]};
   assign dp_state = {30'b0, busy && !hang && (mcnt >= dlat), busy};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         busy <= 1'b0;
         mcnt <= 0;
         res <= '0;
         dp_out_val <= '0;
      end else begin
         case (dp_ctrl)
            32'd1: begin
               busy <= 1'b1;
               mcnt <= 1;
               if (dp_select[0])
                  res <= (db == 64'd0) ? 256'd0 : {128'd0, da % db, da / db};
               else
                  res <= 256'(ma) * 256'(mb);
            end
            32'd2: begin
               busy <= 1'b0;
               mcnt <= 0;
               for (int i = 0; i < 8; i++) regs[i] <= '0;
            end
            32'd3: dp_out_val <= res[32*dp_in_loc[2:0] +: 32];
            default: begin
               if (busy) mcnt <= mcnt + 1;
               else regs[dp_in_loc[2:0]] <= dp_in_val;
            end
         endcase
      end
   end

   // scoreboard
   typedef struct {
      logic         err;
      logic [255:0] data;
      int           lat;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   pass_cnt = 0;
   int   tot_cnt = 0;
   int   rd_cnt, rd_bad, clr_cnt, ctrl_nz, loc_nz;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
      tot_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   task automatic bound_fail(input string name);
      tot_cnt++;
      $display("FAIL %s: wait bound expired, got timeout expected event", name);
   endtask

   initial begin
      logic prev_v;
      int   lat_meas;
      exp_t e;
      prev_v = 1'b0;
      lat_meas = -1;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            acc_q.delete();
            prev_v = 1'b0;
         end else begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (rsp_valid && !prev_v)
               lat_meas = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
            if (dp_ctrl == 32'd3) begin
               if (dp_in_loc != 32'(rd_cnt)) rd_bad++;
               rd_cnt++;
            end
            if (dp_ctrl == 32'd2) clr_cnt++;
            if (dp_ctrl != 32'd0) ctrl_nz++;
            if (dp_in_loc != 32'd0) loc_nz++;
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  bound_fail("unexpected_rsp");
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_err", 256'(rsp_err), 256'(e.err));
                  chk("rsp_data", rsp_data, e.data);
                  if (e.lat >= 0) chk("latency", 256'(lat_meas), 256'(e.lat));
               end
            end
            prev_v = rsp_valid;
         end
      end
   end

   task automatic push_exp(input logic err, input logic [255:0] data, input int lat);
      exp_t e;
      e.err = err;
      e.data = data;
      e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic op, input logic [127:0] a, input logic [127:0] b);
      int t;
      @(negedge clk);
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) bound_fail("cmd_accept");
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !cmd_ready) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         bound_fail("transaction_done");
         exp_q.delete();
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1);
   end

   initial begin
      int t;
      int h;
      int bad;
      logic [255:0] snap;
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = 1'b0;
      cmd_a = '0;
      cmd_b = '0;
      rsp_ready = 1'b1;
      rd_cnt = 0; rd_bad = 0; clr_cnt = 0; ctrl_nz = 0; loc_nz = 0;

      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", 256'(cmd_ready), 256'd0);
      chk("reset_outputs", {rsp_valid, rsp_err, dp_ctrl, dp_in_loc, dp_in_val, dp_select},
          256'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_reset", 256'(cmd_ready), 256'd1);

      // multiply all-ones by 2, done 5 cycles after start
      push_exp(1'b0, 256'h1_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 24);
      send(1'b0, '1, 128'd2);
      wait_done();

      // divide 100 / 7
      rd_cnt = 0; rd_bad = 0;
      push_exp(1'b0, {128'd0, 64'd2, 64'd14}, 20);
      send(1'b1, 128'd100, 128'd7);
      wait_done();
      chk("div_read_count", 256'(rd_cnt), 256'd4);
      chk("div_read_locs", 256'(rd_bad), 256'd0);

      // divide by zero never touches the datapath
      ctrl_nz = 0; loc_nz = 0;
      push_exp(1'b1, 256'd0, 1);
      send(1'b1, 128'd5, 128'd0);
      wait_done();
      chk("div0_ctrl_idle", 256'(ctrl_nz), 256'd0);
      chk("div0_loc_idle", 256'(loc_nz), 256'd0);

      // timeout after 16 wait cycles, then CLEAR
      hang = 1'b1;
      clr_cnt = 0;
      push_exp(1'b1, 256'd0, 26);
      send(1'b0, 128'd3, 128'd3);
      wait_done();
      chk("timeout_clear", 256'(clr_cnt), 256'd1);
      hang = 1'b0;

      // done lands on the last permitted wait cycle: done wins
      dlat = 16;
      push_exp(1'b0, 256'd15, 35);
      send(1'b0, 128'd3, 128'd5);
      wait_done();
      dlat = 5;

      // backpressure with a second command waiting
      rsp_ready = 1'b0;
      push_exp(1'b0, 256'h1_23456789_ABCDEF00, -1);
      push_exp(1'b0, {128'd0, 64'd0, 64'd100}, 20);
      send(1'b0, 128'h12345678_9ABCDEF0, 128'h10);
      cmd_op = 1'b1;
      cmd_a = 128'd1000;
      cmd_b = 128'd10;
      cmd_valid = 1'b1;
      t = 0;
      while (!rsp_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) bound_fail("bp_rsp_valid");
      snap = rsp_data;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_data !== snap || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
      end
      chk("bp_hold_stable", 256'(bad), 256'd0);
      rsp_ready = 1'b1;
      h = cyc;
      t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) bound_fail("bp_second_accept");
      chk("bp_second_accept_cycle", 256'(cyc - h), 256'd2);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done();

      // reset during read j = 3
      send(1'b0, 128'd7, 128'd9);
      t = 0;
      while (!(dp_ctrl == 32'd3 && dp_in_loc == 32'd3) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) bound_fail("read_j3");
      reset = 1'b1;
      #1;
      chk("midop_reset_outputs",
          {cmd_ready, rsp_valid, rsp_err, dp_ctrl, dp_in_loc, dp_in_val, dp_select},
          256'd0);
      chk("midop_reset_data", rsp_data, 256'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midop_cmd_ready", 256'(cmd_ready), 256'd1);
      push_exp(1'b0, 256'd12, 24);
      send(1'b0, 128'd3, 128'd4);
      wait_done();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
